// File: rtl/sparc_ctrl_pkg.sv
// Shared SPARC branch-control definitions: Bicc cond encodings, icc flag bit
// positions and the branch sequencer state type.
package sparc_ctrl_pkg;

    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BLE  = 4'b0010;
    localparam logic [3:0] COND_BL   = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BNE  = 4'b1001;
    localparam logic [3:0] COND_BG   = 4'b1010;
    localparam logic [3:0] COND_BGE  = 4'b1011;
    localparam logic [3:0] COND_BGU  = 4'b1100;
    localparam logic [3:0] COND_BCC  = 4'b1101;
    localparam logic [3:0] COND_BPOS = 4'b1110;
    localparam logic [3:0] COND_BVC  = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CC_WAIT = 2'd1,
        SLOT    = 2'd2
    } br_state_t;

endpackage

// File: rtl/condition_handler.sv
// Evaluates a Bicc cond field against the icc flags; branch_out is the taken
// indication, qualified by a branch actually being present in ID.
module condition_handler
    import sparc_ctrl_pkg::*;
#(
    parameter int COND_W = 4,
    parameter int FLAG_W = 4
) (
    input  logic              ID_branch_instr,
    input  logic [COND_W-1:0] ID_cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              branch_out
);

    logic n, z, v, c;
    logic base;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign c = flags[FLAG_C];

    // The upper cond bit selects the complement of the lower-three-bit test.
    always_comb begin
        base = 1'b0;
        case (ID_cond[2:0])
            3'd0: base = 1'b0;
            3'd1: base = z;
            3'd2: base = z | (n ^ v);
            3'd3: base = n ^ v;
            3'd4: base = c | z;
            3'd5: base = c;
            3'd6: base = n;
            3'd7: base = v;
            default: base = 1'b0;
        endcase
    end

    assign branch_out = ID_branch_instr & (base ^ ID_cond[3]);

endmodule

// File: rtl/branch_sequencer.sv
// Sequences Bicc resolution in ID: icc hazard stall, fetch redirect and
// delay-slot annulment. Optional statistics counters under BRANCH_STATS_EN.
module branch_sequencer
    import sparc_ctrl_pkg::*;
#(
    parameter int COND_W = 4,
    parameter int FLAG_W = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_branch_instr,
    input  logic              ID_annul,
    input  logic [COND_W-1:0] ID_cond,
    input  logic [FLAG_W-1:0] flags,
    input  logic              EX_cc_write,
    input  logic              stall_in,
    output logic              pc_sel,
    output logic              cc_stall,
    output logic              ID_kill,
    output logic              dcti_err,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] taken_cnt,
    output logic [STAT_W-1:0] annul_cnt,
    output br_state_t         fsm_state
);

    br_state_t state_q, state_next;
    logic      annul_r, annul_next;
    logic      dcti_q, set_dcti;
    logic      taken;
    logic      needs_cc;
    logic      cc_hazard;

    condition_handler #(
        .COND_W (COND_W),
        .FLAG_W (FLAG_W)
    ) u_cond (
        .ID_branch_instr (ID_branch_instr),
        .ID_cond         (ID_cond),
        .flags           (flags),
        .branch_out      (taken)
    );

    assign needs_cc  = (ID_cond != COND_BN) && (ID_cond != COND_BA);
    assign cc_hazard = needs_cc & EX_cc_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            annul_r <= 1'b0;
            dcti_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            annul_r <= annul_next;
            if (set_dcti) dcti_q <= 1'b1;
        end
    end

    // stall_in freezes everything: no resolution, no redirect, state held.
    always_comb begin
        state_next = state_q;
        annul_next = annul_r;
        pc_sel     = 1'b0;
        cc_stall   = 1'b0;
        set_dcti   = 1'b0;
        case (state_q)
            IDLE, CC_WAIT: begin
                if (!stall_in && ID_branch_instr) begin
                    if (cc_hazard) begin
                        cc_stall   = 1'b1;
                        state_next = CC_WAIT;
                    end else begin
                        pc_sel     = taken;
                        annul_next = ID_annul & (!taken | (ID_cond == COND_BA));
                        state_next = SLOT;
                    end
                end else if (!stall_in) begin
                    state_next = IDLE;
                end
            end
            SLOT: begin
                if (!stall_in) begin
                    // A branch in a live delay slot is a DCTI couple: never redirect.
                    set_dcti   = !annul_r & ID_branch_instr;
                    annul_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                annul_next = 1'b0;
            end
        endcase
    end

    assign ID_kill   = annul_r;
    assign dcti_err  = dcti_q;
    assign fsm_state = state_q;

`ifdef BRANCH_STATS_EN
    logic              resolve_en;
    logic              annul_done;
    logic [STAT_W-1:0] branch_q, taken_q, annul_q;

    assign resolve_en = (state_q != SLOT) & ID_branch_instr & !stall_in & !cc_hazard;
    assign annul_done = (state_q == SLOT) & !stall_in & annul_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_q <= '0;
            taken_q  <= '0;
            annul_q  <= '0;
        end else begin
            if (resolve_en && (branch_q != '1)) branch_q <= branch_q + 1'b1;
            if (resolve_en && taken && (taken_q != '1)) taken_q <= taken_q + 1'b1;
            if (annul_done && (annul_q != '1)) annul_q <= annul_q + 1'b1;
        end
    end

    assign branch_cnt = branch_q;
    assign taken_cnt  = taken_q;
    assign annul_cnt  = annul_q;
`else
    assign branch_cnt = '0;
    assign taken_cnt  = '0;
    assign annul_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer.
module tb_branch_sequencer;
    import sparc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_branch_instr;
    logic        ID_annul;
    logic [3:0]  ID_cond;
    logic [3:0]  flags;
    logic        EX_cc_write;
    logic        stall_in;
    logic        pc_sel;
    logic        cc_stall;
    logic        ID_kill;
    logic        dcti_err;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;
    logic [15:0] annul_cnt;
    br_state_t   fsm_state;

    int compared   = 0;
    int mismatched = 0;

    branch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .ID_branch_instr (ID_branch_instr),
        .ID_annul        (ID_annul),
        .ID_cond         (ID_cond),
        .flags           (flags),
        .EX_cc_write     (EX_cc_write),
        .stall_in        (stall_in),
        .pc_sel          (pc_sel),
        .cc_stall        (cc_stall),
        .ID_kill         (ID_kill),
        .dcti_err        (dcti_err),
        .branch_cnt      (branch_cnt),
        .taken_cnt       (taken_cnt),
        .annul_cnt       (annul_cnt),
        .fsm_state       (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ID_branch_instr = 1'b0;
        ID_annul        = 1'b0;
        ID_cond         = 4'b0000;
        flags           = 4'b0000;
        EX_cc_write     = 1'b0;
        stall_in        = 1'b0;
    endtask

    task automatic drive_branch(input logic [3:0] cond, input logic a, input logic [3:0] f);
        ID_branch_instr = 1'b1;
        ID_annul        = a;
        ID_cond         = cond;
        flags           = f;
        EX_cc_write     = 1'b0;
        stall_in        = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (fsm_state !== IDLE) begin mismatched++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        compared++; if (ID_kill !== 1'b0) begin mismatched++; $display("FAIL reset_kill: got %0b want 0", ID_kill); end
        compared++; if (dcti_err !== 1'b0) begin mismatched++; $display("FAIL reset_dcti: got %0b want 0", dcti_err); end
        compared++; if (pc_sel !== 1'b0 || cc_stall !== 1'b0) begin mismatched++; $display("FAIL reset_comb: got pc_sel=%0b cc_stall=%0b want 0 0", pc_sel, cc_stall); end
        compared++; if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0 || annul_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0", branch_cnt, taken_cnt, annul_cnt); end
    endtask

    task automatic test_idle_no_branch();
        drive_idle();
        ID_cond = 4'b0001;
        EX_cc_write = 1'b1;
        #1;
        compared++; if (pc_sel !== 1'b0 || cc_stall !== 1'b0) begin mismatched++; $display("FAIL idle_comb: got pc_sel=%0b cc_stall=%0b want 0 0", pc_sel, cc_stall); end
        tick();
        compared++; if (fsm_state !== IDLE || ID_kill !== 1'b0) begin mismatched++; $display("FAIL idle_hold: got state=%0d kill=%0b want 0 0", fsm_state, ID_kill); end
        drive_idle();
    endtask

    task automatic test_ba_no_annul();
        drive_branch(COND_BA, 1'b0, 4'b0000);
        #1;
        compared++; if (pc_sel !== 1'b1 || cc_stall !== 1'b0) begin mismatched++; $display("FAIL ba_pc_sel: got pc_sel=%0b cc_stall=%0b want 1 0", pc_sel, cc_stall); end
        tick();
        drive_idle();
        #1;
        compared++; if (ID_kill !== 1'b0 || fsm_state !== SLOT) begin mismatched++; $display("FAIL ba_slot: got kill=%0b state=%0d want 0 2", ID_kill, fsm_state); end
        compared++; if (pc_sel !== 1'b0) begin mismatched++; $display("FAIL ba_slot_pc: got %0b want 0", pc_sel); end
        tick();
        compared++; if (fsm_state !== IDLE || ID_kill !== 1'b0) begin mismatched++; $display("FAIL ba_exit: got state=%0d kill=%0b want 0 0", fsm_state, ID_kill); end
    endtask

    task automatic test_be_annul();
        drive_branch(COND_BE, 1'b1, 4'b0100);
        #1;
        compared++; if (pc_sel !== 1'b1) begin mismatched++; $display("FAIL be_taken_pc: got %0b want 1", pc_sel); end
        tick();
        drive_idle();
        compared++; if (ID_kill !== 1'b0) begin mismatched++; $display("FAIL be_taken_kill: got %0b want 0", ID_kill); end
        tick();
        drive_branch(COND_BE, 1'b1, 4'b0000);
        #1;
        compared++; if (pc_sel !== 1'b0) begin mismatched++; $display("FAIL be_nt_pc: got %0b want 0", pc_sel); end
        tick();
        drive_idle();
        compared++; if (ID_kill !== 1'b1) begin mismatched++; $display("FAIL be_nt_kill: got %0b want 1", ID_kill); end
        tick();
        compared++; if (ID_kill !== 1'b0 || fsm_state !== IDLE) begin mismatched++; $display("FAIL be_nt_exit: got kill=%0b state=%0d want 0 0", ID_kill, fsm_state); end
        drive_branch(COND_BA, 1'b1, 4'b0000);
        #1;
        compared++; if (pc_sel !== 1'b1) begin mismatched++; $display("FAIL ba_a_pc: got %0b want 1", pc_sel); end
        tick();
        drive_idle();
        compared++; if (ID_kill !== 1'b1) begin mismatched++; $display("FAIL ba_a_kill: got %0b want 1", ID_kill); end
        tick();
    endtask

    task automatic test_cond_table();
        logic [3:0] conds [8] = '{COND_BLE, COND_BGU, COND_BCC, COND_BVS, COND_BNEG, COND_BN, COND_BGE, COND_BPOS};
        logic [3:0] fl    [8] = '{4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1111, 4'b1000, 4'b0111};
        logic       exp   [8] = '{1'b1,   1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b1};
        for (int i = 0; i < 8; i++) begin
            drive_branch(conds[i], 1'b0, fl[i]);
            #1;
            compared++; if (pc_sel !== exp[i]) begin mismatched++; $display("FAIL cond_%0d: cond=%b flags=%b got %0b want %0b", i, conds[i], fl[i], pc_sel, exp[i]); end
            tick();
            drive_idle();
            tick();
        end
    endtask

    task automatic test_cc_hazard();
        drive_branch(COND_BE, 1'b0, 4'b0000);
        EX_cc_write = 1'b1;
        #1;
        compared++; if (cc_stall !== 1'b1 || pc_sel !== 1'b0) begin mismatched++; $display("FAIL haz_stall: got cc_stall=%0b pc_sel=%0b want 1 0", cc_stall, pc_sel); end
        tick();
        compared++; if (fsm_state !== CC_WAIT) begin mismatched++; $display("FAIL haz_state: got %0d want 1", fsm_state); end
        EX_cc_write = 1'b0;
        flags = 4'b0100;
        #1;
        compared++; if (pc_sel !== 1'b1 || cc_stall !== 1'b0) begin mismatched++; $display("FAIL haz_resolve: got pc_sel=%0b cc_stall=%0b want 1 0", pc_sel, cc_stall); end
        tick();
        drive_idle();
        compared++; if (fsm_state !== SLOT || ID_kill !== 1'b0) begin mismatched++; $display("FAIL haz_slot: got state=%0d kill=%0b want 2 0", fsm_state, ID_kill); end
        tick();
        // BA needs no icc, so an EX write must not stall it
        drive_branch(COND_BA, 1'b0, 4'b0000);
        EX_cc_write = 1'b1;
        #1;
        compared++; if (cc_stall !== 1'b0 || pc_sel !== 1'b1) begin mismatched++; $display("FAIL haz_ba: got cc_stall=%0b pc_sel=%0b want 0 1", cc_stall, pc_sel); end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_stall_in();
        drive_branch(COND_BA, 1'b0, 4'b0000);
        stall_in = 1'b1;
        #1;
        compared++; if (pc_sel !== 1'b0 || cc_stall !== 1'b0) begin mismatched++; $display("FAIL stall_idle_comb: got pc_sel=%0b cc_stall=%0b want 0 0", pc_sel, cc_stall); end
        tick();
        compared++; if (fsm_state !== IDLE) begin mismatched++; $display("FAIL stall_idle_state: got %0d want 0", fsm_state); end
        drive_branch(COND_BE, 1'b1, 4'b0000);
        tick();
        drive_idle();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++; if (ID_kill !== 1'b1 || pc_sel !== 1'b0 || fsm_state !== SLOT) begin mismatched++; $display("FAIL stall_slot_%0d: got kill=%0b pc_sel=%0b state=%0d want 1 0 2", i, ID_kill, pc_sel, fsm_state); end
            tick();
        end
        stall_in = 1'b0;
        #1;
        compared++; if (ID_kill !== 1'b1 || fsm_state !== SLOT) begin mismatched++; $display("FAIL stall_release: got kill=%0b state=%0d want 1 2", ID_kill, fsm_state); end
        tick();
        compared++; if (fsm_state !== IDLE || ID_kill !== 1'b0) begin mismatched++; $display("FAIL stall_exit: got state=%0d kill=%0b want 0 0", fsm_state, ID_kill); end
    endtask

    task automatic test_reset_in_slot();
        drive_branch(COND_BA, 1'b1, 4'b0000);
        tick();
        drive_idle();
        compared++; if (ID_kill !== 1'b1) begin mismatched++; $display("FAIL rslot_pre: got %0b want 1", ID_kill); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++; if (ID_kill !== 1'b0 || fsm_state !== IDLE) begin mismatched++; $display("FAIL rslot_post: got kill=%0b state=%0d want 0 0", ID_kill, fsm_state); end
    endtask

    task automatic test_dcti();
        drive_branch(COND_BA, 1'b0, 4'b0000);
        tick();
        drive_branch(COND_BA, 1'b0, 4'b0000);
        #1;
        compared++; if (pc_sel !== 1'b0) begin mismatched++; $display("FAIL dcti_pc: got %0b want 0", pc_sel); end
        tick();
        drive_idle();
        compared++; if (dcti_err !== 1'b1 || fsm_state !== IDLE) begin mismatched++; $display("FAIL dcti_set: got err=%0b state=%0d want 1 0", dcti_err, fsm_state); end
        tick();
        tick();
        compared++; if (dcti_err !== 1'b1) begin mismatched++; $display("FAIL dcti_sticky: got %0b want 1", dcti_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++; if (dcti_err !== 1'b0) begin mismatched++; $display("FAIL dcti_clear: got %0b want 0", dcti_err); end
        // Branch in an annulled slot is killed, so it is not an error
        drive_branch(COND_BE, 1'b1, 4'b0000);
        tick();
        drive_branch(COND_BA, 1'b0, 4'b0000);
        tick();
        drive_idle();
        compared++; if (dcti_err !== 1'b0) begin mismatched++; $display("FAIL dcti_annulled: got %0b want 0", dcti_err); end
    endtask

    task automatic test_stats();
        logic [15:0] exp_b, exp_t, exp_a;
        do_reset();
        drive_branch(COND_BA, 1'b0, 4'b0000);
        tick();
        drive_idle();
        tick();
        drive_branch(COND_BE, 1'b0, 4'b0100);
        tick();
        drive_idle();
        tick();
        drive_branch(COND_BE, 1'b1, 4'b0000);
        tick();
        drive_idle();
        tick();
`ifdef BRANCH_STATS_EN
        exp_b = 16'd3; exp_t = 16'd2; exp_a = 16'd1;
`else
        exp_b = 16'd0; exp_t = 16'd0; exp_a = 16'd0;
`endif
        compared++; if (branch_cnt !== exp_b) begin mismatched++; $display("FAIL stats_branch: got %0d want %0d", branch_cnt, exp_b); end
        compared++; if (taken_cnt !== exp_t) begin mismatched++; $display("FAIL stats_taken: got %0d want %0d", taken_cnt, exp_t); end
        compared++; if (annul_cnt !== exp_a) begin mismatched++; $display("FAIL stats_annul: got %0d want %0d", annul_cnt, exp_a); end
        do_reset();
        compared++; if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0 || annul_cnt !== 16'd0) begin mismatched++; $display("FAIL stats_reset: got %0d %0d %0d want 0 0 0", branch_cnt, taken_cnt, annul_cnt); end
    endtask

    // pc_sel and cc_stall are mutually exclusive at every sample point
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            compared++;
            if (pc_sel === 1'b1 && cc_stall === 1'b1) begin
                mismatched++;
                $display("FAIL excl: got pc_sel=1 cc_stall=1 want not both");
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_idle_no_branch();
        test_ba_no_annul();
        test_be_annul();
        test_cond_table();
        test_cc_hazard();
        test_stall_in();
        test_reset_in_slot();
        test_dcti();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
